// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the sequenced ALU control decoder.
// Optional MULDIV path: enabled by defining ALU_CTRL_SEQ_MULDIV_EN.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        AOP_LDST   = 2'b00,
        AOP_BRANCH = 2'b01,
        AOP_RTYPE  = 2'b10,
        AOP_ITYPE  = 2'b11
    } aluop_e;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SLL    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MULDIV = 4'b1111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_e;

    // Operation selected by funct3 alone when funct7 is the base encoding
    function automatic logic [3:0] f3_base_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of ALUop/funct7/funct3 into {code, illegal, is_md}.
// The M-op decode exists only when ALU_CTRL_SEQ_MULDIV_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic [3:0] code_o,
    output logic       illegal_o,
    output logic       is_md_o
);

    // Decode table; anything undecodable reports illegal with an ADD code
    always_comb begin
        code_o    = ALU_ADD;
        illegal_o = 1'b0;
        is_md_o   = 1'b0;
        case (aluop_e'(alu_op_i))
            AOP_LDST: begin
                code_o = ALU_ADD;
            end
            AOP_BRANCH: begin
                code_o = ALU_SUB;
            end
            AOP_RTYPE: begin
                if (funct7_i == F7_BASE) begin
                    code_o = f3_base_op(funct3_i);
                end else if ((funct7_i == F7_ALT) && (funct3_i == 3'b000)) begin
                    code_o = ALU_SUB;
                end else if ((funct7_i == F7_ALT) && (funct3_i == 3'b101)) begin
                    code_o = ALU_SRA;
`ifdef ALU_CTRL_SEQ_MULDIV_EN
                end else if (funct7_i == F7_MULDIV) begin
                    code_o  = ALU_MULDIV;
                    is_md_o = 1'b1;
`endif
                end else begin
                    code_o    = ALU_ADD;
                    illegal_o = 1'b1;
                end
            end
            AOP_ITYPE: begin
                // funct7 is immediate bits except for the shift encodings
                if (funct3_i == 3'b001) begin
                    if (funct7_i == F7_BASE) begin
                        code_o = ALU_SLL;
                    end else begin
                        code_o    = ALU_ADD;
                        illegal_o = 1'b1;
                    end
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == F7_BASE) begin
                        code_o = ALU_SRL;
                    end else if (funct7_i == F7_ALT) begin
                        code_o = ALU_SRA;
                    end else begin
                        code_o    = ALU_ADD;
                        illegal_o = 1'b1;
                    end
                end else begin
                    code_o = f3_base_op(funct3_i);
                end
            end
            default: begin
                code_o    = ALU_ADD;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, valid/ready ALU control decoder with optional multi-cycle MULDIV path.
// Optional MULDIV path: enabled by defining ALU_CTRL_SEQ_MULDIV_EN.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int MD_LAT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] alu_ctrl,
    output logic            illegal,
    output logic            md_start,
    output logic [2:0]      md_op
);

    logic [3:0]      dec_code_s;
    logic            dec_illegal_s;
    logic            dec_is_md_s;
    logic            accept_s;
    logic            drain_s;
    logic            out_valid_q;
    logic [OP_W-1:0] alu_ctrl_q;
    logic            illegal_q;

    alu_ctrl_decode u_decode (
        .alu_op_i  (alu_op),
        .funct7_i  (funct7),
        .funct3_i  (funct3),
        .code_o    (dec_code_s),
        .illegal_o (dec_illegal_s),
        .is_md_o   (dec_is_md_s)
    );

    assign accept_s  = in_valid && in_ready;
    assign drain_s   = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign illegal   = illegal_q;

`ifdef ALU_CTRL_SEQ_MULDIV_EN
    localparam int CNT_W = $clog2(MD_LAT + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             md_start_q;
    logic [2:0]       md_op_q;

    assign in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign md_start = md_start_q && !rst;
    assign md_op    = md_op_q;

    // IDLE/MD_BUSY sequencer with busy counter and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            illegal_q   <= 1'b0;
            md_start_q  <= 1'b0;
            md_op_q     <= 3'b000;
        end else begin
            md_start_q <= 1'b0;
            md_op_q    <= 3'b000;
            if (drain_s) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (dec_is_md_s) begin
                            md_start_q <= 1'b1;
                            md_op_q    <= funct3;
                            cnt_q      <= CNT_W'(MD_LAT);
                            state_q    <= ST_MD_BUSY;
                        end else begin
                            out_valid_q <= 1'b1;
                            alu_ctrl_q  <= OP_W'(dec_code_s);
                            illegal_q   <= dec_illegal_s;
                        end
                    end
                end
                ST_MD_BUSY: begin
                    // The launch cycle (md_start high) precedes the MD_LAT busy cycles
                    if (md_start_q) begin
                        cnt_q <= cnt_q;
                    end else if (cnt_q == CNT_W'(1)) begin
                        out_valid_q <= 1'b1;
                        alu_ctrl_q  <= OP_W'(ALU_MULDIV);
                        illegal_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
`else
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign md_start = 1'b0;
    assign md_op    = 3'b000;

    // Single-stage result register; an M-op can never be flagged legal here
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (drain_s) begin
                out_valid_q <= 1'b0;
            end
            if (accept_s) begin
                out_valid_q <= 1'b1;
                alu_ctrl_q  <= OP_W'(dec_code_s);
                illegal_q   <= dec_illegal_s | dec_is_md_s;
            end
        end
    end
`endif

endmodule
